// File: rtl/keypad_emu_pkg.sv
// Shared types and key-code helpers for the 4x4 matrix keypad emulator.
package keypad_emu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[1:0];
  endfunction

  // Index to active-low one-hot, as seen on the matrix pins.
  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] row_pattern(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key request handshake between a requester (master) and the keypad emulator (slave).
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       abort;
  logic       busy;
  logic       done;

  modport master (
    output key_valid, key_code, abort,
    input  key_ready, busy, done
  );

  modport slave (
    input  key_valid, key_code, abort,
    output key_ready, busy, done
  );
endinterface

// File: rtl/keypad_emulator_col_visit_detect.sv
// Detects start/end of scanner visits to the target column.
// KEYPAD_EMU_SYNC_EN adds a 2-flop synchronizer on col_n for an asynchronous scanner.
module col_visit_detect
  import keypad_emu_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] col_n,
  input  logic [3:0] target,
  output logic       rise,
  output logic       fall
);

  logic [3:0] col_s;
  logic       match;
  logic       match_q;

`ifdef KEYPAD_EMU_SYNC_EN
  logic [3:0] col_meta;
  logic [3:0] col_sync;

  // Reset to the idle bus value so no phantom visit appears out of reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      col_meta <= ROW_IDLE;
      col_sync <= ROW_IDLE;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign col_s = col_sync;
`else
  assign col_s = col_n;
`endif

  // target is always one-hot, so idle or multi-low strobes can never match.
  assign match = (col_s == target);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) match_q <= 1'b0;
    else     match_q <= match;
  end

  assign rise = match & ~match_q;
  assign fall = ~match & match_q;

endmodule

// File: rtl/keypad_emulator.sv
// One-key 4x4 active-low keypad emulator responding to a column-scanning reader.
// Define KEYPAD_EMU_SYNC_EN to synchronize col_n before visit counting.
module keypad_emulator
  import keypad_emu_pkg::*;
#(
  parameter int unsigned HOLD_SCANS = 8,
  parameter int unsigned GAP_SCANS  = 4
) (
  input  logic               clk,
  input  logic               res,
  keypad_emulator_if.slave   key,
  input  logic [3:0]         col_n,
  output logic [3:0]         row_n
);

  localparam int unsigned CNT_MAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_SCANS);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_SCANS - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code_q;
  logic             done_q;

  logic [3:0] target_col;
  logic [3:0] drive_row;
  logic       rise;
  logic       fall;

  assign target_col = col_pattern(key_col(code_q));
  assign drive_row  = row_pattern(key_row(code_q));

  col_visit_detect u_visit (
    .clk    (clk),
    .res    (res),
    .col_n  (col_n),
    .target (target_col),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state  <= IDLE;
      cnt    <= '0;
      code_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (key.abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (key.key_valid) begin
              code_q <= key.key_code;
              cnt    <= '0;
              state  <= PRESS;
            end
          end
          PRESS: begin
            // Leaving only on a fall guarantees the final counted visit ran to completion.
            if (fall && cnt == HOLD_C) begin
              cnt   <= '0;
              state <= GAP;
            end else if (rise && cnt != HOLD_C) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (rise) begin
              if (cnt == GAP_LAST) begin
                cnt    <= '0;
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Switch-like path: raw col_n straight to row_n; async reset forces IDLE, releasing the row at once.
  // NOTE: default assignment first so every path writes row_n and no latch is inferred.
  always_comb begin
    row_n = ROW_IDLE;
    if (state == PRESS && col_n == target_col) row_n = drive_row;
  end

  assign key.key_ready = (state == IDLE);
  assign key.busy      = (state != IDLE);
  assign key.done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (HOLD_SCANS=2, GAP_SCANS=1, 16-clk scan).
module tb_keypad_emulator;

`ifdef KEYPAD_EMU_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       res;
  logic [3:0] col_n;
  logic [3:0] row_n;

  int n_checks = 0;
  int n_errors = 0;

  keypad_emulator_if kif ();

  keypad_emulator #(
    .HOLD_SCANS (2),
    .GAP_SCANS  (1)
  ) dut (
    .clk   (clk),
    .res   (res),
    .key   (kif),
    .col_n (col_n),
    .row_n (row_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scanner visits columns 0..3, 4 clocks each.
  function automatic logic [3:0] scan_col(input int k);
    case ((k / 4) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Idle the column bus, then present a request; accept happens at the next edge.
  task automatic present(input logic [3:0] code);
    col_n = 4'b1111;
    repeat (3) cyc();
    kif.key_code  = code;
    kif.key_valid = 1'b1;
    #1;
    check($sformatf("rdy_pre_%0d", code), 8'(kif.key_ready), 8'd1);
  endtask

  task automatic do_abort(input string tag);
    kif.abort = 1'b1;
    cyc();
    kif.abort = 1'b0;
    #1;
    check({tag, "_rdy"},  8'(kif.key_ready), 8'd1);
    check({tag, "_done"}, 8'(kif.done),      8'd0);
  endtask

  initial begin
    logic [3:0] exp_row;

    res           = 1'b1;
    col_n         = 4'b1111;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    kif.abort     = 1'b0;
    repeat (2) cyc();
    check("rst_row",  8'(row_n),         8'h0f);
    check("rst_rdy",  8'(kif.key_ready), 8'd1);
    check("rst_busy", 8'(kif.busy),      8'd0);
    check("rst_done", 8'(kif.done),      8'd0);
    res = 1'b0;

    // Key 6: drive 1011 only in column 1101; 2 held visits, 1 gap visit, then done.
    present(4'd6);
    for (int k = 0; k < 46; k++) begin
      cyc();
      if (k == 0) kif.key_valid = 1'b0;
      col_n = scan_col(k);
      #1;
      exp_row = ((k >= 4 && k <= 7) || (k >= 20 && k <= 23)) ? 4'b1011 : 4'b1111;
      check($sformatf("k6_row_%0d", k), 8'(row_n),         8'(exp_row));
      check($sformatf("k6_done_%0d", k), 8'(kif.done),     8'(k == 37 + LAT));
      check($sformatf("k6_rdy_%0d", k), 8'(kif.key_ready), 8'(k >= 37 + LAT));
    end

    // Key 15: only column 0111 drives row 0111.
    present(4'd15);
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k == 0) kif.key_valid = 1'b0;
      col_n = scan_col(k);
      #1;
      exp_row = (k >= 12) ? 4'b0111 : 4'b1111;
      check($sformatf("k15_row_%0d", k), 8'(row_n), 8'(exp_row));
    end
    do_abort("k15_abort");

    // Key 0: only column 1110 drives row 1110.
    present(4'd0);
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k == 0) kif.key_valid = 1'b0;
      col_n = scan_col(k);
      #1;
      exp_row = (k <= 3) ? 4'b1110 : 4'b1111;
      check($sformatf("k0_row_%0d", k), 8'(row_n), 8'(exp_row));
    end
    do_abort("k0_abort");

    // Key 3 with a stuck/garbage column bus: no drive, stays busy until abort.
    present(4'd3);
    cyc();
    kif.key_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      col_n = 4'b1111;
      cyc();
      check($sformatf("k3_stuck_row_%0d", k), 8'(row_n),    8'h0f);
      check($sformatf("k3_stuck_busy_%0d", k), 8'(kif.busy), 8'd1);
    end
    col_n = 4'b1100;
    repeat (4) cyc();
    check("k3_multi_row", 8'(row_n), 8'h0f);
    col_n = 4'b0000;
    cyc();
    check("k3_all_row", 8'(row_n), 8'h0f);
    col_n = 4'b1110;
    #1;
    check("k3_live_row0", 8'(row_n), 8'h07);
    cyc();
    check("k3_live_row1", 8'(row_n), 8'h07);
    col_n = 4'b1111;
    repeat (4) cyc();
    check("k3_busy_end", 8'(kif.busy), 8'd1);
    kif.key_valid = 1'b1;
    kif.key_code  = 4'd5;
    do_abort("k3_abort");
    kif.abort = 1'b1;
    cyc();
    kif.abort     = 1'b0;
    kif.key_valid = 1'b0;
    #1;
    check("abort_prio_rdy", 8'(kif.key_ready), 8'd1);

    // Key 9 with key_valid held: key_code change ignored, re-accept (key 2) in done cycle.
    present(4'd9);
    for (int k = 0; k < 52; k++) begin
      cyc();
      if (k == 0) kif.key_code = 4'd2;
      col_n = scan_col(k);
      #1;
      if ((k >= 8 && k <= 11) || (k >= 24 && k <= 27)) exp_row = 4'b1101;
      else if (k >= 48)                                exp_row = 4'b1011;
      else                                             exp_row = 4'b1111;
      check($sformatf("k9_row_%0d", k), 8'(row_n),         8'(exp_row));
      check($sformatf("k9_done_%0d", k), 8'(kif.done),     8'(k == 41 + LAT));
      check($sformatf("k9_rdy_%0d", k), 8'(kif.key_ready), 8'(k == 41 + LAT));
    end
    kif.key_valid = 1'b0;
    do_abort("k9_abort");

    // Asynchronous reset mid-press releases the row immediately.
    present(4'd6);
    cyc();
    kif.key_valid = 1'b0;
    col_n = 4'b1101;
    #1;
    check("res_pre_row0", 8'(row_n), 8'h0b);
    cyc();
    check("res_pre_row1", 8'(row_n), 8'h0b);
    #2;
    res = 1'b1;
    #1;
    check("res_row",  8'(row_n),         8'h0f);
    check("res_rdy",  8'(kif.key_ready), 8'd1);
    check("res_done", 8'(kif.done),      8'd0);
    cyc();
    res = 1'b0;
    #1;
    check("res_post_row", 8'(row_n),         8'h0f);
    check("res_post_rdy", 8'(kif.key_ready), 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Emulates one key of the 4x4 active-low matrix keypad at the row/column pins, as the responder to the column-scanning keypad reader. On a handshake it accepts a 4-bit key code. It then drives the matching row line low whenever the scanner strobes that key's column, holds the press for a set number of complete scans, then releases for a set gap. Used in loopback builds and benches in place of the physical keypad.

## Interface
- HOLD_SCANS, 8, target-column visits the key stays pressed (≥1)
- GAP_SCANS, 4, target-column visits with key released before the next key is accepted (≥1)
- clk  in  1  system clock
- res  in  1  reset; one clock; reset is asynchronous and active-high
- key_valid  in  1  request to press key_code
- key_code  in  4  key value = 4*column + row, 0..15
- key_ready  out  1  high in IDLE; accept when key_valid & key_ready
- abort  in  1  cancel press/gap immediately
- col_n  in  4  column strobe from scanner, active-low one-hot
- row_n  out  4  row lines to scanner, active-low
- busy  out  1  ~key_ready
- done  out  1  one-cycle pulse when a press+gap sequence completes

## Operation
- Key mapping: col = key_code[3:2], row = key_code[1:0]. The target column pattern is ~(1<<col). The drive pattern is ~(1<<row).
- Example: key 6 gives column pattern 1101 and row drive 1011. Key 0 gives 1110 / 1110.
- States:
  - IDLE: row_n=1111, key_ready=1. Accept latches key_code and clears cnt, then goes to PRESS.
  - PRESS: row_n = drive pattern when col_n equals the target pattern exactly, else 1111. This is combinational from raw col_n with no register, like a physical switch.
  - GAP: row_n=1111.
- Visit detection: match = (col_s == target pattern). rise = match & ~match_q. fall = ~match & match_q.
- PRESS: cnt++ on rise, saturating at HOLD_SCANS. When fall occurs and cnt==HOLD_SCANS, clear cnt and go to GAP. This guarantees the last visit is complete.
- GAP: cnt++ on rise. When cnt reaches GAP_SCANS, go to IDLE and assert done.
- abort: from any state, go to IDLE next edge. cnt is cleared and done is not asserted. abort has priority over key_valid and all counting.
- col_n that is not one-hot (1111, several lows) never matches. row_n stays 1111 and no visit is counted.
- col_n stuck idle leaves the block in PRESS/GAP indefinitely. abort is the only exit.
- cnt width is $clog2(max(HOLD_SCANS,GAP_SCANS)+1).

## Timing
- Reset values: state IDLE, row_n=1111, key_ready=1, busy=0, done=0, cnt=0, match_q=0, captured code=0.
- Accept at edge N: PRESS from N+1. row_n responds to col_n in the same cycle with zero latency.
- done is registered. It is high for exactly the first IDLE cycle after GAP, with key_ready=1 in that cycle. An accept in the done cycle is legal.
- Visit detection latency: 1 cycle without the sync option, 3 cycles with it. row_n latency is unaffected by the option.
- res asserted mid-press releases row_n to 1111 asynchronously.
- key_code changes after accept have no effect.

## Configuration
- KEYPAD_EMU_SYNC_EN defined: col_n passes through a 2-flop synchronizer (reset 1111) before match/visit detection. Use when the scanner runs on an unrelated clock.
- Undefined: col_s = col_n directly.
- row_n is always combinational from raw col_n.

## Structure
- Package keypad_emu_pkg holds:
  - state enum IDLE/PRESS/GAP
  - constant ROW_IDLE = 4'b1111
  - functions key_col(code) and key_row(code), plus col_pattern/row_pattern (index -> active-low one-hot)
- One sub-module, col_visit_detect: optional synchronizer plus match/rise/fall from col_n and the target pattern.

## Test plan
Default bench: HOLD_SCANS=2, GAP_SCANS=1. col_n cycles 1110, 1101, 1011, 0111, each held 4 clk (16-clk scan).

- Key 6 accepted, then: row_n=1011 only while col_n=1101, 1111 otherwise. Exactly 2 such visits, then 1 released visit, then done for one cycle, key_ready=1.
- Key 15: row_n=0111 during col_n=0111. Key 0: row_n=1110 during col_n=1110. No drive in any other column.
- col_n forced to 1111 after accepting key 3: row_n stays 1111, busy stays 1. abort gives IDLE next cycle with done=0.
- key_valid held with key 9 through done: second accept occurs in the done cycle. A key_code change to 2 during PRESS is ignored.
- res pulse during PRESS while col_n matches: row_n goes to 1111 immediately, key_ready=1, done=0.
- Build with KEYPAD_EMU_SYNC_EN: same sequence as the first scenario, press end/done delayed 2 cycles, row_n timing unchanged.
